// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the configuration frame loader: FSM states,
// header field positions and the default session-opening sync word.
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_STROBE,
    ST_HOLD
  } state_t;

  localparam int HDR_DESYNC_BIT = 31;
  localparam int HDR_COL_MSB    = 15;
  localparam int HDR_COL_LSB    = 8;
  localparam int HDR_FRAME_MSB  = 7;
  localparam int HDR_FRAME_LSB  = 0;

  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFAB0_FAB1;

endpackage

// File: rtl/onehot_decoder.sv
// Index-plus-enable to one-hot decoder; an index beyond WIDTH-1 yields all zeros.
module onehot_decoder #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 8
) (
  input  logic [IDX_W-1:0] index,
  input  logic             enable,
  output logic [WIDTH-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (enable && (index == IDX_W'(i))) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/config_frame_loader.sv
// Bitstream front end: waits for the sync word, then turns header/data word
// pairs into a frame row plus a single-cycle one-hot frame/column strobe.
module config_frame_loader
  import cfg_loader_pkg::*;
#(
  parameter int          FrameBitsPerRow = 32,
  parameter int          MaxFramesPerCol = 32,
  parameter int          NumberOfCols    = 16,
  parameter logic [31:0] SyncWord        = SYNC_WORD_DEFAULT
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [31:0]                WriteData,
  input  logic                       WriteStrobe,
  output logic                       Ready,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [NumberOfCols-1:0]    ColSelect,
  output logic                       ConfigActive,
  output logic                       Error
);

  state_t state, state_next;

  logic       accept;
  logic [7:0] hdr_col;
  logic [7:0] hdr_frame;
  logic       hdr_desync;
  logic       hdr_bad;
  logic [7:0] col_q;
  logic [7:0] frame_q;
  logic       pair_ok_q;
  logic       strobe_fire;
  logic [MaxFramesPerCol-1:0] frame_dec;
  logic [NumberOfCols-1:0]    col_dec;

  assign Ready      = (state == ST_IDLE) || (state == ST_HDR) || (state == ST_DATA);
  assign accept     = WriteStrobe && Ready;
  assign hdr_col    = WriteData[HDR_COL_MSB:HDR_COL_LSB];
  assign hdr_frame  = WriteData[HDR_FRAME_MSB:HDR_FRAME_LSB];
  assign hdr_desync = WriteData[HDR_DESYNC_BIT];
  assign hdr_bad    = (int'(hdr_col) >= NumberOfCols) || (int'(hdr_frame) >= MaxFramesPerCol);

  // Strobes are registered off the data-accept edge so they rise together with FrameData.
  assign strobe_fire = (state == ST_DATA) && accept && pair_ok_q;

  onehot_decoder #(.WIDTH(MaxFramesPerCol), .IDX_W(8)) u_frame_dec (
    .index  (frame_q),
    .enable (strobe_fire),
    .onehot (frame_dec)
  );

  onehot_decoder #(.WIDTH(NumberOfCols), .IDX_W(8)) u_col_dec (
    .index  (col_q),
    .enable (strobe_fire),
    .onehot (col_dec)
  );

  always_ff @(posedge CLK) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept && (WriteData == SyncWord)) state_next = ST_HDR;
      ST_HDR:    if (accept) state_next = hdr_desync ? ST_IDLE : ST_DATA;
      ST_DATA:   if (accept) state_next = pair_ok_q ? ST_STROBE : ST_HDR;
      ST_STROBE: state_next = ST_HOLD;
      ST_HOLD:   state_next = ST_HDR;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      FrameData    <= '0;
      FrameStrobe  <= '0;
      ColSelect    <= '0;
      ConfigActive <= 1'b0;
      Error        <= 1'b0;
    end else begin
      FrameStrobe <= frame_dec;
      ColSelect   <= col_dec;
      if ((state == ST_IDLE) && accept && (WriteData == SyncWord)) ConfigActive <= 1'b1;
      if ((state == ST_HDR) && accept) begin
        if (hdr_desync)   ConfigActive <= 1'b0;
        else if (hdr_bad) Error        <= 1'b1;
      end
      if ((state == ST_DATA) && accept) FrameData <= WriteData[FrameBitsPerRow-1:0];
    end
  end

  // Header fields are plain data; only meaningful once a header has been accepted.
  always_ff @(posedge CLK) begin
    if ((state == ST_HDR) && accept && !hdr_desync) begin
      col_q     <= hdr_col;
      frame_q   <= hdr_frame;
      pair_ok_q <= !hdr_bad;
    end
  end

endmodule
